// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like fetch and data ports onto single-beat AXI4 master reads and writes.
// Serves one request at a time; data requests win arbitration and fetches can be discarded by flush.
module sram_axi_bridge #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_sram_en,
   input  logic [3:0]        inst_sram_wen,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   input  logic [31:0]       inst_sram_wdata,
   output logic [31:0]       inst_sram_rdata,
   output logic              fetch_available,
   input  logic              data_sram_en,
   input  logic [3:0]        data_sram_wen,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [31:0]       data_sram_wdata,
   input  logic [3:0]        data_sram_sel,
   output logic [31:0]       data_sram_rdata,
   output logic              memory_available,
   input  logic              flush,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [2:0]        arsize,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [31:0]       rdata,
   input  logic              rvalid,
   output logic              rready,
   output logic [ADDR_W-1:0] awaddr,
   output logic [2:0]        awsize,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bvalid,
   output logic              bready
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW_W = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wen_q, wen_d;
   logic [2:0]        size_q, size_d;
   logic              src_data_q, src_data_d;
   logic              discard_q, discard_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic [31:0]       inst_rdata_q, inst_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;

   // Fetch write fields and the read ID carry no information for this bridge.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rid};

   function automatic logic [2:0] size_from_sel(input logic [3:0] sel);
      case (sel)
         4'b1111:                            return 3'd2;
         4'b0011, 4'b1100:                   return 3'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
         default:                            return 3'd2;
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wen_d        = wen_q;
      size_d       = size_q;
      src_data_d   = src_data_q;
      discard_d    = discard_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (!flush && data_sram_en) begin
               addr_d     = data_sram_addr;
               wdata_d    = data_sram_wdata;
               wen_d      = data_sram_wen;
               size_d     = size_from_sel(data_sram_sel);
               src_data_d = 1'b1;
               if (data_sram_wen != 4'b0000) begin
                  state_d   = S_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = S_AR;
               end
            end else if (!flush && inst_sram_en) begin
               addr_d     = inst_sram_addr;
               wdata_d    = 32'h0;
               wen_d      = 4'b0000;
               size_d     = 3'd2;
               src_data_d = 1'b0;
               state_d    = S_AR;
            end
         end
         S_AR: begin
            if (arready) state_d = S_R;
         end
         S_R: begin
            if (rvalid) begin
               state_d = S_DONE;
               if (src_data_q) begin
                  data_rdata_d = rdata;
               end else if (!(discard_q || flush)) begin
                  inst_rdata_d = rdata;
               end
            end
         end
         S_AW_W: begin
            // Address and data channels retire independently, possibly in the same cycle.
            awvalid_d = awvalid_q && !awready;
            wvalid_d  = wvalid_q && !wready;
            if (!awvalid_d && !wvalid_d) state_d = S_B;
         end
         S_B: begin
            if (bvalid) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_q != S_IDLE && !src_data_q && flush) discard_d = 1'b1;
      if (state_d == S_IDLE) discard_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and clears every register, including captured read data.
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wen_q        <= '0;
         size_q       <= '0;
         src_data_q   <= 1'b0;
         discard_q    <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         size_q       <= size_d;
         src_data_q   <= src_data_d;
         discard_q    <= discard_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign arid    = src_data_q ? ID_W'(1) : '0;
   assign araddr  = addr_q;
   assign arsize  = size_q;
   assign arvalid = (state_q == S_AR);
   assign rready  = (state_q == S_R);

   assign awaddr  = addr_q;
   assign awsize  = size_q;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wen_q;
   assign wvalid  = wvalid_q;
   assign bready  = (state_q == S_B);

   assign inst_sram_rdata  = inst_rdata_q;
   assign data_sram_rdata  = data_rdata_q;
   assign fetch_available  = (state_q == S_DONE) && !src_data_q && !discard_q;
   assign memory_available = (state_q == S_DONE) && src_data_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: vector table plus hand sequences, with a
// delay-programmable AXI slave model and scoreboard queues for AR/AW/W and completions.
module tb_sram_axi_bridge;

   typedef struct {
      bit          is_data;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [2:0]  exp_size;
      int          exp_lat;
      bit          flush_mid;
   } vec_t;

   typedef struct { logic [31:0] addr; logic [3:0] id; logic [2:0] size; } ar_exp_t;
   typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
   typedef struct { bit is_data; bit is_write; logic [31:0] rdata; } comp_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        fetch_available;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [3:0]  data_sram_sel;
   logic [31:0] data_sram_rdata;
   logic        memory_available;
   logic        flush;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int total = 0;
   int bad   = 0;

   int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   int r_hs_count = 0;

   ar_exp_t   ar_q[$];
   aw_exp_t   aw_q[$];
   w_exp_t    w_q[$];
   comp_exp_t comp_q[$];

   sram_axi_bridge #(.ID_W(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata), .fetch_available(fetch_available),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_sel(data_sram_sel), .data_sram_rdata(data_sram_rdata),
      .memory_available(memory_available), .flush(flush),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // Backing store of the slave: a fixed boot word plus an address-derived pattern.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1FC0_0000) return 32'h3C1D_BFC0;
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // AXI slave model; handshake checks happen when the slave commits its ready/valid.
   initial begin
      int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      logic [31:0] rd_addr;
      logic [3:0]  rd_id;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      rd_addr = 32'h0; rd_id = 4'h0;
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rid = 4'h0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else begin
            if (arvalid) begin
               arready = (ar_cnt >= ar_delay);
               ar_cnt++;
               if (arready) begin
                  rd_addr = araddr;
                  rd_id   = arid;
                  if (ar_q.size() == 0) fail("ar_unexpected");
                  else begin
                     ar_exp_t e;
                     e = ar_q.pop_front();
                     check("ar_addr", araddr, e.addr);
                     check("ar_id", 32'(arid), 32'(e.id));
                     check("ar_size", 32'(arsize), 32'(e.size));
                  end
               end
            end else begin
               arready = 1'b0;
               ar_cnt  = 0;
            end

            if (rready) begin
               rvalid = (r_cnt >= r_delay);
               rid    = rd_id;
               rdata  = rvalid ? mem_word(rd_addr) : 32'h0;
               if (rvalid) r_hs_count++;
               r_cnt++;
            end else begin
               rvalid = 1'b0;
               r_cnt  = 0;
            end

            if (awvalid) begin
               awready = (aw_cnt >= aw_delay);
               aw_cnt++;
               if (awready) begin
                  if (aw_q.size() == 0) fail("aw_unexpected");
                  else begin
                     aw_exp_t e;
                     e = aw_q.pop_front();
                     check("aw_addr", awaddr, e.addr);
                     check("aw_size", 32'(awsize), 32'(e.size));
                  end
               end
            end else begin
               awready = 1'b0;
               aw_cnt  = 0;
            end

            if (wvalid) begin
               wready = (w_cnt >= w_delay);
               w_cnt++;
               if (wready) begin
                  if (w_q.size() == 0) fail("w_unexpected");
                  else begin
                     w_exp_t e;
                     e = w_q.pop_front();
                     check("w_data", wdata, e.data);
                     check("w_strb", 32'(wstrb), 32'(e.strb));
                  end
               end
            end else begin
               wready = 1'b0;
               w_cnt  = 0;
            end

            if (bready) begin
               bvalid = (b_cnt >= b_delay);
               b_cnt++;
            end else begin
               bvalid = 1'b0;
               b_cnt  = 0;
            end
         end
      end
   end

   // Completion scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (fetch_available && memory_available) fail("both_available");
         if (fetch_available || memory_available) begin
            if (comp_q.size() == 0) fail("completion_unexpected");
            else begin
               comp_exp_t e;
               e = comp_q.pop_front();
               check("done_src", 32'(memory_available), 32'(e.is_data));
               if (!e.is_write)
                  check("done_rdata", memory_available ? data_sram_rdata : inst_sram_rdata, e.rdata);
            end
         end
      end
   end

   task automatic push_expect(input vec_t v, input bit expect_done);
      comp_exp_t c;
      if (!v.is_data || v.wen == 4'b0000) begin
         ar_exp_t a;
         a.addr = v.addr; a.id = v.is_data ? 4'd1 : 4'd0; a.size = v.exp_size;
         ar_q.push_back(a);
      end else begin
         aw_exp_t aw;
         w_exp_t  w;
         aw.addr = v.addr; aw.size = v.exp_size;
         w.data = v.wdata; w.strb = v.wen;
         aw_q.push_back(aw);
         w_q.push_back(w);
      end
      c.is_data  = v.is_data;
      c.is_write = v.is_data && (v.wen != 4'b0000);
      c.rdata    = mem_word(v.addr);
      if (expect_done) comp_q.push_back(c);
   endtask

   task automatic drive_req(input vec_t v);
      inst_sram_en    = !v.is_data;
      data_sram_en    = v.is_data;
      inst_sram_addr  = v.addr;
      data_sram_addr  = v.addr;
      data_sram_wen   = v.wen;
      data_sram_wdata = v.wdata;
      data_sram_sel   = v.sel;
      inst_sram_wen   = 4'hF;
      inst_sram_wdata = 32'hFFFF_FFFF;
   endtask

   // Issues one request from a negedge and waits for its completion pulse.
   task automatic run_req(input vec_t v, output int lat, output int ar_cyc, output int aw_cyc,
                          output int w_cyc, output int ar_unstable);
      lat = 0; ar_cyc = 0; aw_cyc = 0; w_cyc = 0; ar_unstable = 0;
      push_expect(v, 1'b1);
      drive_req(v);
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         flush = v.flush_mid && (i == 1);
         if (arvalid) begin
            ar_cyc++;
            if (araddr !== v.addr || arid !== (v.is_data ? 4'd1 : 4'd0)) ar_unstable++;
         end
         if (awvalid) aw_cyc++;
         if (wvalid) w_cyc++;
         if (fetch_available || memory_available) begin
            lat = i;
            break;
         end
      end
      flush = 1'b0;
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      if (lat == 0) fail("req_timeout");
   endtask

   task automatic check_reset_state(input string p);
      check({p, "_arvalid"}, 32'(arvalid), 32'h0);
      check({p, "_rready"}, 32'(rready), 32'h0);
      check({p, "_awvalid"}, 32'(awvalid), 32'h0);
      check({p, "_wvalid"}, 32'(wvalid), 32'h0);
      check({p, "_bready"}, 32'(bready), 32'h0);
      check({p, "_fetch_avail"}, 32'(fetch_available), 32'h0);
      check({p, "_mem_avail"}, 32'(memory_available), 32'h0);
      check({p, "_inst_rdata"}, inst_sram_rdata, 32'h0);
      check({p, "_data_rdata"}, data_sram_rdata, 32'h0);
      check({p, "_addr"}, araddr, 32'h0);
      check({p, "_wstrb"}, 32'(wstrb), 32'h0);
   endtask

   initial begin
      vec_t vt[7];
      vec_t v;
      int lat, ar_cyc, aw_cyc, w_cyc, ar_bad;
      int t_mem, t_f, fa, hs0, seen;
      logic [31:0] prev;

      vt[0] = '{0, 4'b0000, 32'h1FC0_0000, 32'h0,         4'b1111, 3'd2, 3, 0};
      vt[1] = '{1, 4'b0000, 32'h0000_2000, 32'h0,         4'b1111, 3'd2, 3, 0};
      vt[2] = '{1, 4'b0000, 32'h0000_1006, 32'h0,         4'b1100, 3'd1, 3, 1};
      vt[3] = '{1, 4'b0000, 32'h0000_1003, 32'h0,         4'b1000, 3'd0, 3, 0};
      vt[4] = '{1, 4'b1111, 32'h0000_2004, 32'h1234_5678, 4'b1111, 3'd2, 3, 0};
      vt[5] = '{1, 4'b0010, 32'h0000_2009, 32'h0000_AB00, 4'b0010, 3'd0, 3, 0};
      vt[6] = '{1, 4'b0011, 32'h0000_200C, 32'h0000_CAFE, 4'b0011, 3'd1, 3, 0};

      rst = 1'b1; flush = 1'b0;
      inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
      data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
      data_sram_sel = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_req(vt[i], lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
         @(negedge clk);
      end

      // Simultaneous requests: data first, fetch follows four cycles later.
      inst_sram_en = 1'b1; inst_sram_addr = 32'h1FC0_0010;
      v = '{0, 4'b0000, 32'h1FC0_0010, 32'h0, 4'b1111, 3'd2, 3, 0};
      push_expect('{1, 4'b0000, 32'h0000_1004, 32'h0, 4'b0011, 3'd1, 3, 0}, 1'b1);
      push_expect(v, 1'b1);
      data_sram_en = 1'b1; data_sram_addr = 32'h0000_1004; data_sram_wen = 4'b0000;
      data_sram_sel = 4'b0011;
      t_mem = 0; t_f = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (memory_available) begin
            t_mem = i;
            data_sram_en = 1'b0;
         end
         if (fetch_available) begin
            t_f = i;
            break;
         end
      end
      inst_sram_en = 1'b0;
      check("prio_data_latency", 32'(t_mem), 32'd3);
      check("prio_fetch_gap", 32'(t_f - t_mem), 32'd4);
      @(negedge clk);

      // Store with delayed awready, immediate wready.
      aw_delay = 2;
      v = '{1, 4'b0100, 32'h0000_3000, 32'hDEAD_BEEF, 4'b0100, 3'd0, 5, 0};
      run_req(v, lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
      check("store_aw_latency", 32'(lat), 32'd5);
      check("store_awvalid_cycles", 32'(aw_cyc), 32'd3);
      check("store_wvalid_cycles", 32'(w_cyc), 32'd1);
      @(negedge clk);

      // Store with delayed wready, immediate awready.
      aw_delay = 0; w_delay = 3;
      v = '{1, 4'b1111, 32'h0000_3004, 32'h0BAD_F00D, 4'b1111, 3'd2, 6, 0};
      run_req(v, lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
      check("store_w_latency", 32'(lat), 32'd6);
      check("store_w_awvalid_cycles", 32'(aw_cyc), 32'd1);
      check("store_w_wvalid_cycles", 32'(w_cyc), 32'd4);
      w_delay = 0;
      @(negedge clk);

      // Flush while a fetch waits in R: read completes, nothing delivered.
      r_delay = 2;
      prev = inst_sram_rdata;
      hs0 = r_hs_count;
      v = '{0, 4'b0000, 32'h1FC0_0020, 32'h0, 4'b1111, 3'd2, 3, 0};
      push_expect(v, 1'b0);
      drive_req(v);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rready) begin
            seen = 1;
            break;
         end
      end
      flush = 1'b1;
      inst_sram_en = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      fa = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (fetch_available) fa++;
      end
      check("flush_reached_r", 32'(seen), 32'd1);
      check("flush_no_fetch_avail", 32'(fa), 32'd0);
      check("flush_r_handshakes", 32'(r_hs_count - hs0), 32'd1);
      check("flush_rdata_held", inst_sram_rdata, prev);
      r_delay = 0;

      // Flush in IDLE blocks acceptance; the next cycle accepts normally.
      flush = 1'b1;
      inst_sram_en = 1'b1; inst_sram_addr = 32'h1FC0_0000;
      @(negedge clk);
      check("flush_idle_no_accept", 32'(arvalid), 32'd0);
      flush = 1'b0;
      run_req(vt[0], lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
      check("after_flush_latency", 32'(lat), 32'd3);
      @(negedge clk);

      // arready held low for five cycles.
      ar_delay = 5;
      v = '{0, 4'b0000, 32'h1FC0_0040, 32'h0, 4'b1111, 3'd2, 8, 0};
      run_req(v, lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
      check("arwait_latency", 32'(lat), 32'd8);
      check("arwait_arvalid_cycles", 32'(ar_cyc), 32'd6);
      check("arwait_ar_stable", 32'(ar_bad), 32'd0);
      ar_delay = 0;
      @(negedge clk);

      // Reset while waiting in B.
      b_delay = 10;
      v = '{1, 4'b1111, 32'h0000_4000, 32'h55AA_55AA, 4'b1111, 3'd2, 3, 0};
      push_expect(v, 1'b1);
      drive_req(v);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bready) begin
            seen = 1;
            break;
         end
      end
      data_sram_en = 1'b0;
      check("rst_reached_b", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("midrst");
      comp_q.delete();
      b_delay = 0;
      rst = 1'b0;
      @(negedge clk);
      run_req(vt[0], lat, ar_cyc, aw_cyc, w_cyc, ar_bad);
      check("after_rst_latency", 32'(lat), 32'd3);
      repeat (3) @(negedge clk);

      check("scoreboard_drained", 32'(comp_q.size() + ar_q.size() + aw_q.size() + w_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Responder end of the CPU core's SRAM-like instruction and data ports.
- Accepts one fetch or data request at a time and returns read data with a single-cycle fetch_available / memory_available completion pulse.
- Performs each access as a single-beat AXI4 master transaction toward the system interconnect.
- Sits between the core top and the AXI crossbar; addresses arrive already physical (translated in the core).

Parameters:
- ID_W, 4, AXI ID width; instruction ID = 0, data ID = 1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_sram_en  in  1  fetch request
- inst_sram_wen  in  4  ignored (fetch is read-only)
- inst_sram_addr  in  32  fetch physical address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  fetch data, valid while fetch_available=1
- fetch_available  out  1  fetch completion pulse
- data_sram_en  in  1  data request
- data_sram_wen  in  4  byte write strobes; 0 = read
- data_sram_addr  in  32  data physical address
- data_sram_wdata  in  32  store data
- data_sram_sel  in  4  byte lanes accessed
- data_sram_rdata  out  32  load data, valid while memory_available=1
- memory_available  out  1  data completion pulse
- flush  in  1  pipeline flush from the core control unit
- arid  out  ID_W  read ID
- araddr  out  32  read address
- arsize  out  3  read size
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rid  in  ID_W  read response ID
- rdata  in  32  read data
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address
- awsize  out  3  write size
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready
- Constant AXI fields (not listed as ports): len=0, burst=INCR, wlast=1, awid=1, all cache/prot/lock fields 0.

Behaviour:
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE, arbitration:
  - data_sram_en has priority over inst_sram_en.
  - The chosen request's addr, wdata, wen and size are registered, plus a src flag (inst/data).
  - Read (inst, or data with wen==0) → AR; data with wen!=0 → AW_W.
- AR:
  - arvalid=1; arid = 0 for inst, 1 for data; araddr held stable.
  - On arvalid&arready → R.
- R:
  - rready=1.
  - On rvalid → capture rdata into the matching rdata output register, → DONE.
- AW_W:
  - awvalid and wvalid both asserted on entry.
  - Each is dropped independently after its own handshake; both handshakes may occur in the same cycle.
  - When both are done → B.
- B:
  - bready=1.
  - On bvalid → DONE.
- DONE:
  - One cycle: fetch_available=1 if src=inst, else memory_available=1.
  - Then → IDLE.
  - IDLE does not re-sample in this cycle, so the core has exactly one cycle to advance its request.
- Size encoding:
  - arsize is 2 for inst.
  - For data, size derives from sel: 4'b1111→2; 4'b0011 or 4'b1100→1; one-hot→0.
  - wstrb = registered wen.
- Latency with a zero-wait slave:
  - Read: request seen in IDLE at cycle N; available at N+3.
  - Write: available at N+3.
  - Back-to-back requests issue every 4 cycles.
- Flush:
  - flush=1 during any non-IDLE state of an inst transaction sets a discard flag.
  - In DONE with discard set, fetch_available stays 0 and inst_sram_rdata is not updated.
  - The AXI transaction always runs to completion; it is never abandoned.
  - Data transactions are unaffected by flush.
  - The discard flag is cleared on IDLE entry.
- flush in IDLE: no request is accepted that cycle.
- rdata outputs hold their last captured value between completions.
- Reset: state=IDLE; all valid/ready outputs 0; available outputs 0; rdata outputs 0; discard 0; registered request fields 0. Reset mid-transaction returns to IDLE next cycle; the slave shares the same rst.

Test Plan:
- Single fetch, addr 0x1FC00000, arready=1, rvalid next cycle with rdata 0x3C1DBFC0 → arid=0, arsize=2, fetch_available pulses once at N+3 with inst_sram_rdata=0x3C1DBFC0.
- inst_sram_en and data_sram_en both high (data read 0x00001004, sel=0011) → data served first: arid=1, arsize=1, memory_available pulse; fetch issued 4 cycles later.
- Store 0xDEADBEEF with wen=4'b0100, awready delayed 2 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles, wstrb=0100, memory_available after bvalid.
- flush asserted while fetch is in R → AXI read completes with rready handshake, fetch_available stays 0, inst_sram_rdata unchanged.
- arready held low 5 cycles → araddr/arid stable throughout, no available pulse until the full read completes.
- rst asserted while in B → next cycle all valids/readies 0, state IDLE, outputs zero, a new fetch is accepted afterward.
